score_board_text: RTL and testbench
===================================

Name: score_board_text

Overview:
Parametrised successor to the fixed 16x16 scoreboard character map. It holds a registered BCD score table for N players, fed by the local score and two external board links with valid strobes. Each slot tracks presence and timeout. The block answers char_xy lookups with a registered ASCII code and reports the current leader. It sits between the game/link logic and the text-mode font renderer.

Parameters:
N_PLAYERS, 3, number of score slots; player IDs 1..N_PLAYERS; 1 <= N_PLAYERS <= 2^ID_W-1 and N_PLAYERS+3 <= ROWS
ID_W, 2, board/player ID width
DIGITS, 6, BCD digits per score
COLS, 16, characters per row; must be >= 10+DIGITS
ROWS, 16, rows; must be a power of two
TIMEOUT, 50_000_000, cycles without an update before a slot is marked absent; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
char_xy  in  log2(ROWS)+log2(COLS)  {row, col} of the requested character
char_req  in  1  lookup request strobe
board_id  in  ID_W  this board's player ID
points  in  4*DIGITS  local BCD score, most significant digit first
points_vld  in  1  local score update strobe
ext_data_1  in  4*DIGITS+ID_W  {id, BCD score} from link 1
ext_vld_1  in  1  link 1 update strobe
ext_data_2  in  4*DIGITS+ID_W  {id, BCD score} from link 2
ext_vld_2  in  1  link 2 update strobe
char_code  out  7  ASCII code
char_vld  out  1  char_code valid
leader_id  out  ID_W  ID of the leading present player; 0 when no slot is present
err_cnt  out  8  count of rejected update frames, saturating

Behaviour:
- Decided: one clock, clk; reset rst is synchronous, active-high.
- Reset values: all scores 0, all present flags 0, timeout counters 0, char_code 7'h20, char_vld 0, leader_id 0, err_cnt 0.
- Update acceptance: a frame is accepted only when its strobe is high, its ID is in 1..N_PLAYERS, and every nibble is <= 9.
  - A frame with a strobe but a bad ID or a nibble > 9 is dropped and increments err_cnt by 1, saturating at 255.
  - Several dropped frames in one cycle add their count.
- Conflicts on the same slot in the same cycle: priority is local > ext_1 > ext_2; losing frames are discarded silently, with no error.
- Updates to different slots in the same cycle all apply.
- Write timing: an accepted write updates the score on the next edge, sets the slot's present flag, and clears its timeout counter.
- Timeout, per slot: the counter increments while the slot is present and not written.
  - When it reaches TIMEOUT-1, present clears; the score is retained.
  - A write in that same cycle wins: present stays 1 and the counter clears.
- Leader: registered; reflects the score/present state from the previous cycle, so 1 cycle after the table changes.
  - Highest score among present slots, compared as unsigned BCD (equivalent to binary compare of the packed nibbles).
  - Ties go to the lowest ID; no present slot gives 0.
- Lookup: 1-cycle latency.
  - char_vld(t+1) = char_req(t).
  - char_code(t+1) is the glyph for char_xy(t), evaluated against the table state at t.
  - With no request, char_code holds its previous value.
- Screen layout, with r = row and c = col:
  - r=0: ">>>>>SCORE:<<<<<" in cols 0..15; cols >= 16 are space.
  - r=1..N_PLAYERS: "Player", then ASCII digit r at col 6, ':' at col 7, spaces at cols 8..COLS-DIGITS-1, then score digits at cols COLS-DIGITS..COLS-1 as {3'b011, nibble}. If the slot is absent, every digit column shows '-' (7'h2D).
  - r=N_PLAYERS+2: "You are Player" + ASCII board_id + "!" in cols 0..15.
  - All other rows/cols: space.
- board_id outside 1..N_PLAYERS: the r=N_PLAYERS+2 row shows '?' in place of the digit.
- Reset asserted mid-lookup: char_vld is 0 on the next cycle and the pending request is lost.

Optional Feature:
SCORE_BOARD_LEADER_MARK_EN
- Defined: on row leader_id, col 9 shows '*' (7'h2A) instead of space, but only when leader_id != 0.
- Undefined: col 9 is always space.
- leader_id is output in both builds.

Decomposition:
- Package score_board_pkg: ASCII constants (SPACE, COLON, DASH, STAR, digit base 7'h30), the header and "You are Player" string constants, and function bcd_valid(nibble vector).
- Sub-module score_slot, instantiated N_PLAYERS times: score register, present flag, timeout counter, with write-enable/data in and score/present out.
- Top level holds: arbitration, err_cnt, leader compare tree, lookup mux and output register.

Test Plan:
- Reset, then char_req at {0,5} → next cycle char_vld=1, char_code=7'h53 'S'; leader_id=0; row 1 col 10 returns '-'.
- board_id=1, points=24'h000123, points_vld for 1 cycle → row1 cols 10..15 read "000123"; leader_id=1 two cycles after the strobe.
- Same cycle: points_vld with ID 2 score 000500, ext_vld_1 with {2, 000900}, ext_vld_2 with {3, 000900} → slot2=000500, slot3=000900, leader_id=3, err_cnt=0.
- ext_vld_1 with {2'd0, 24'h000001} and ext_vld_2 with {3, 24'h0000A1} in the same cycle → both dropped, err_cnt=2, table unchanged.
- TIMEOUT=10, write slot 3 once → slot 3 present for 10 cycles, then row 3 shows dashes and leader_id recomputes. Repeat with a write landing in cycle 9 → slot stays present.
- Slots 1 and 2 both 000777 → leader_id=1. With SCORE_BOARD_LEADER_MARK_EN, {1,9} reads '*' and {2,9} reads space.

Source files
------------

// File: rtl/score_board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : score_board_pkg
//  Description : Shared ASCII constants, fixed screen strings and the BCD
//                validity helper for the score board text map.
//  Revision    : 1.0 - initial release
// ============================================================================
package score_board_pkg;

   // Largest score width the BCD helper can check (in digits)
   localparam int c_MAX_DIGITS = 16;

   // ASCII glyphs used by the screen layout
   localparam logic [6:0] c_SPACE  = 7'h20;
   localparam logic [6:0] c_COLON  = 7'h3A;
   localparam logic [6:0] c_DASH   = 7'h2D;
   localparam logic [6:0] c_STAR   = 7'h2A;
   localparam logic [6:0] c_DIGIT0 = 7'h30;
   localparam logic [6:0] c_QMARK  = 7'h3F;
   localparam logic [6:0] c_EXCL   = 7'h21;

   // Fixed strings, first character in the most significant byte
   localparam logic [8*16-1:0] c_HDR_STR    = ">>>>>SCORE:<<<<<";
   localparam logic [8*6-1:0]  c_PLAYER_STR = "Player";
   localparam logic [8*14-1:0] c_YOU_STR    = "You are Player";

   // True when every nibble of the vector is a decimal digit (0..9).
   // Narrower scores are zero-extended by the caller; zero nibbles pass.
   function automatic logic bcd_valid(input logic [4*c_MAX_DIGITS-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < c_MAX_DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/score_board_text_slot.sv
`default_nettype none
// ============================================================================
//  Module      : score_slot
//  Description : One player entry: BCD score register, present flag and
//                inactivity counter. A write always wins over a timeout
//                in the same cycle. TIMEOUT = 0 disables aging.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_slot
   import score_board_pkg::*;
#(
   parameter int DIGITS  = 6,
   parameter int TIMEOUT = 50_000_000
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_we,
   input  logic [4*DIGITS-1:0] i_data,
   output logic [4*DIGITS-1:0] o_score,
   output logic                o_present
);

   localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST = (TIMEOUT > 1) ? c_CNT_W'(TIMEOUT - 1) : '0;

   logic [4*DIGITS-1:0] r_score;
   logic                r_present;
   logic [c_CNT_W-1:0]  r_cnt;

   // Score/presence update; the score is retained when the slot ages out
   always_ff @(posedge clk) begin
      if (rst) begin
         r_score   <= '0;
         r_present <= 1'b0;
         r_cnt     <= '0;
      end else if (i_we) begin
         r_score   <= i_data;
         r_present <= 1'b1;
         r_cnt     <= '0;
      end else if ((TIMEOUT != 0) && r_present) begin
         if (r_cnt == c_LAST) begin
            r_present <= 1'b0;
            r_cnt     <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_score   = r_score;
   assign o_present = r_present;

endmodule
`default_nettype wire

// File: rtl/score_board_text.sv
`default_nettype none
// ============================================================================
//  Module      : score_board_text
//  Description : N-player BCD score table fed by the local score and two
//                board links, with leader tracking and a registered
//                character lookup for the text-mode renderer.
//                Optional build macro SCORE_BOARD_LEADER_MARK_EN puts a '*'
//                at column 9 of the leading player's row.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_board_text
   import score_board_pkg::*;
#(
   parameter int N_PLAYERS = 3,
   parameter int ID_W      = 2,
   parameter int DIGITS    = 6,
   parameter int COLS      = 16,
   parameter int ROWS      = 16,
   parameter int TIMEOUT   = 50_000_000
)(
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [$clog2(ROWS)+$clog2(COLS)-1:0]   char_xy,
   input  logic                                   char_req,
   input  logic [ID_W-1:0]                        board_id,
   input  logic [4*DIGITS-1:0]                    points,
   input  logic                                   points_vld,
   input  logic [4*DIGITS+ID_W-1:0]               ext_data_1,
   input  logic                                   ext_vld_1,
   input  logic [4*DIGITS+ID_W-1:0]               ext_data_2,
   input  logic                                   ext_vld_2,
   output logic [6:0]                             char_code,
   output logic                                   char_vld,
   output logic [ID_W-1:0]                        leader_id,
   output logic [7:0]                             err_cnt
);

   localparam int c_ROW_W = $clog2(ROWS);
   localparam int c_COL_W = $clog2(COLS);
   localparam int c_SW    = 4 * DIGITS;
   localparam int c_NSRC  = 3;
   localparam logic [ID_W-1:0] c_NP = ID_W'(N_PLAYERS);

   // ------------------------------------------------------------------
   // Update sources, index 0 has the highest priority
   // ------------------------------------------------------------------
   logic            w_src_vld  [c_NSRC];
   logic [ID_W-1:0] w_src_id   [c_NSRC];
   logic [c_SW-1:0] w_src_data [c_NSRC];
   logic            w_src_ok   [c_NSRC];
   logic            w_src_bad  [c_NSRC];

   // Unpack the three frames and classify each as accepted or rejected
   always_comb begin
      w_src_vld[0]  = points_vld;
      w_src_id[0]   = board_id;
      w_src_data[0] = points;
      w_src_vld[1]  = ext_vld_1;
      w_src_id[1]   = ext_data_1[c_SW +: ID_W];
      w_src_data[1] = ext_data_1[c_SW-1:0];
      w_src_vld[2]  = ext_vld_2;
      w_src_id[2]   = ext_data_2[c_SW +: ID_W];
      w_src_data[2] = ext_data_2[c_SW-1:0];
      for (int s = 0; s < c_NSRC; s++) begin
         w_src_ok[s]  = w_src_vld[s] && (w_src_id[s] != '0) && (w_src_id[s] <= c_NP)
                        && bcd_valid((4*c_MAX_DIGITS)'(w_src_data[s]));
         w_src_bad[s] = w_src_vld[s] && !w_src_ok[s];
      end
   end

   // ------------------------------------------------------------------
   // Per-slot arbitration and slot storage
   // ------------------------------------------------------------------
   logic            w_we      [N_PLAYERS];
   logic [c_SW-1:0] w_wdata   [N_PLAYERS];
   logic [c_SW-1:0] w_score   [N_PLAYERS];
   logic            w_present [N_PLAYERS];

   // Lowest-priority source first so the local frame overrides on conflict
   always_comb begin
      for (int i = 0; i < N_PLAYERS; i++) begin
         w_we[i]    = 1'b0;
         w_wdata[i] = '0;
         for (int s = c_NSRC - 1; s >= 0; s--) begin
            if (w_src_ok[s] && (w_src_id[s] == ID_W'(i + 1))) begin
               w_we[i]    = 1'b1;
               w_wdata[i] = w_src_data[s];
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < N_PLAYERS; g++) begin : g_slot
         score_slot #(
            .DIGITS  (DIGITS),
            .TIMEOUT (TIMEOUT)
         ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .i_we      (w_we[g]),
            .i_data    (w_wdata[g]),
            .o_score   (w_score[g]),
            .o_present (w_present[g])
         );
      end
   endgenerate

   // ------------------------------------------------------------------
   // Rejected-frame counter
   // ------------------------------------------------------------------
   logic [1:0] w_err_inc;
   logic [8:0] w_err_sum;
   logic [7:0] r_err_cnt;

   // Number of frames dropped this cycle and the unsaturated new total
   always_comb begin
      w_err_inc = 2'(w_src_bad[0]) + 2'(w_src_bad[1]) + 2'(w_src_bad[2]);
      w_err_sum = {1'b0, r_err_cnt} + 9'(w_err_inc);
   end

   // Saturating accumulate of dropped frames
   always_ff @(posedge clk) begin
      if (rst) r_err_cnt <= '0;
      else     r_err_cnt <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
   end

   // ------------------------------------------------------------------
   // Leader: strict greater-than keeps the lowest ID on a tie
   // ------------------------------------------------------------------
   logic [ID_W-1:0] w_best_id;
   logic [c_SW-1:0] w_best_score;
   logic [ID_W-1:0] r_leader_id;

   // Scan present slots for the highest packed BCD score
   always_comb begin
      w_best_id    = '0;
      w_best_score = '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (w_present[i] && ((w_best_id == '0) || (w_score[i] > w_best_score))) begin
            w_best_id    = ID_W'(i + 1);
            w_best_score = w_score[i];
         end
      end
   end

   // Register the leader one cycle behind the table
   always_ff @(posedge clk) begin
      if (rst) r_leader_id <= '0;
      else     r_leader_id <= w_best_id;
   end

   // ------------------------------------------------------------------
   // Character lookup
   // ------------------------------------------------------------------
   logic [c_ROW_W-1:0] w_row;
   logic [c_COL_W-1:0] w_col;
   int                 w_r;
   int                 w_c;
   int                 w_dig;
   logic [c_SW-1:0]    w_sel_score;
   logic               w_sel_present;
   logic               w_id_ok;
   logic [6:0]         w_glyph;

   // Glyph for the requested {row, col} against the current table
   always_comb begin
      w_row         = char_xy[c_ROW_W+c_COL_W-1 : c_COL_W];
      w_col         = char_xy[c_COL_W-1:0];
      w_r           = int'(w_row);
      w_c           = int'(w_col);
      w_dig         = w_c - (COLS - DIGITS);
      w_sel_score   = '0;
      w_sel_present = 1'b0;
      w_id_ok       = (board_id != '0) && (board_id <= c_NP);
      w_glyph       = c_SPACE;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (w_r == i + 1) begin
            w_sel_score   = w_score[i];
            w_sel_present = w_present[i];
         end
      end
      if (w_r == 0) begin
         if (w_c < 16) w_glyph = c_HDR_STR[8*(15 - w_c) +: 7];
      end else if (w_r <= N_PLAYERS) begin
         if (w_c < 6) begin
            w_glyph = c_PLAYER_STR[8*(5 - w_c) +: 7];
         end else if (w_c == 6) begin
            w_glyph = c_DIGIT0 + 7'(w_row);
         end else if (w_c == 7) begin
            w_glyph = c_COLON;
         end else if ((w_dig >= 0) && (w_dig < DIGITS)) begin
            w_glyph = w_sel_present ? {3'b011, w_sel_score[4*(DIGITS-1-w_dig) +: 4]} : c_DASH;
`ifdef SCORE_BOARD_LEADER_MARK_EN
         end else if ((w_c == 9) && (r_leader_id != '0) && (w_r == int'(r_leader_id))) begin
            w_glyph = c_STAR;
`endif
         end
      end else if (w_r == N_PLAYERS + 2) begin
         if (w_c < 14)       w_glyph = c_YOU_STR[8*(13 - w_c) +: 7];
         else if (w_c == 14) w_glyph = w_id_ok ? (c_DIGIT0 + 7'(board_id)) : c_QMARK;
         else if (w_c == 15) w_glyph = c_EXCL;
      end
   end

   logic [6:0] r_char_code;
   logic       r_char_vld;

   // Output register: valid follows the request, code holds without one
   always_ff @(posedge clk) begin
      if (rst) begin
         r_char_code <= c_SPACE;
         r_char_vld  <= 1'b0;
      end else begin
         r_char_vld <= char_req;
         if (char_req) r_char_code <= w_glyph;
      end
   end

   assign char_code = r_char_code;
   assign char_vld  = r_char_vld;
   assign leader_id = r_leader_id;
   assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_score_board_text.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_board_text
//  Description : Self-checking bench for score_board_text with a glyph
//                scoreboard queue and a small spec-level table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_board_text;

   localparam int TO = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  char_xy = '0;
   logic        char_req = 1'b0;
   logic [1:0]  board_id = 2'd1;
   logic [23:0] points = '0;
   logic        points_vld = 1'b0;
   logic [25:0] ext_data_1 = '0;
   logic        ext_vld_1 = 1'b0;
   logic [25:0] ext_data_2 = '0;
   logic        ext_vld_2 = 1'b0;
   logic [6:0]  char_code;
   logic        char_vld;
   logic [1:0]  leader_id;
   logic [7:0]  err_cnt;

   score_board_text #(
      .N_PLAYERS (3), .ID_W (2), .DIGITS (6), .COLS (16), .ROWS (16), .TIMEOUT (TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_xy    (char_xy),
      .char_req   (char_req),
      .board_id   (board_id),
      .points     (points),
      .points_vld (points_vld),
      .ext_data_1 (ext_data_1),
      .ext_vld_1  (ext_vld_1),
      .ext_data_2 (ext_data_2),
      .ext_vld_2  (ext_vld_2),
      .char_code  (char_code),
      .char_vld   (char_vld),
      .leader_id  (leader_id),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   bit chk_leader = 1'b0;
   logic [6:0] exp_q[$];

   // Model: latest and previous write cycle / score per slot (1..3)
   int          m_wr[4];
   int          m_wr_prev[4];
   logic [23:0] m_score[4];
   logic [23:0] m_old[4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_pres(int i, int x);
      int w;
      w = (x > m_wr[i]) ? m_wr[i] : m_wr_prev[i];
      return (x - w >= 1) && (x - w <= TO);
   endfunction

   function automatic logic [23:0] m_sc(int i, int x);
      return (x > m_wr[i]) ? m_score[i] : m_old[i];
   endfunction

   function automatic int model_leader(int x);
      int best = 0;
      logic [23:0] bs = '0;
      for (int i = 1; i <= 3; i++) begin
         if (m_pres(i, x) && (best == 0 || m_sc(i, x) > bs)) begin
            best = i;
            bs   = m_sc(i, x);
         end
      end
      return best;
   endfunction

   function automatic string exp_row(int r, int x);
      string s;
      s = "                ";
      if (r == 0) s = ">>>>>SCORE:<<<<<";
      else if (r >= 1 && r <= 3) begin
         if (m_pres(r, x)) s = $sformatf("Player%0d:  %06h", r, m_sc(r, x));
         else              s = $sformatf("Player%0d:  ------", r);
`ifdef SCORE_BOARD_LEADER_MARK_EN
         if (model_leader(x - 1) == r) s.putc(9, "*");
`endif
      end else if (r == 5) begin
         if (board_id >= 2'd1 && board_id <= 2'd3) s = $sformatf("You are Player%0d!", board_id);
         else                                      s = "You are Player?!";
      end
      return s;
   endfunction

   // Record an expected slot write that lands at the end of this cycle
   task automatic model_set(input int i, input logic [23:0] sc);
      m_wr_prev[i] = m_wr[i];
      m_old[i]     = m_score[i];
      m_wr[i]      = cyc;
      m_score[i]   = sc;
   endtask

   task automatic lookup(input int r, input int c);
      string s;
      logic [7:0] b;
      s = exp_row(r, cyc);
      b = s[c];
      char_xy  = {4'(r), 4'(c)};
      char_req = 1'b1;
      exp_q.push_back(b[6:0]);
      tick();
      char_req = 1'b0;
   endtask

   task automatic drive(input logic lv, input logic [23:0] lp,
                        input logic e1v, input logic [25:0] e1,
                        input logic e2v, input logic [25:0] e2);
      points_vld = lv;  points = lp;
      ext_vld_1  = e1v; ext_data_1 = e1;
      ext_vld_2  = e2v; ext_data_2 = e2;
      tick();
      points_vld = 1'b0; ext_vld_1 = 1'b0; ext_vld_2 = 1'b0;
   endtask

   // Pop the scoreboard whenever the DUT presents a character
   always @(negedge clk) begin
      if (char_vld) begin
         if (exp_q.size() == 0) check_eq("char_vld_unexpected", 32'(char_vld), 32'd0);
         else                   check_eq("char_code", 32'(char_code), 32'(exp_q.pop_front()));
      end
   end

   // Leader tracks the model table one cycle behind
   always @(negedge clk) begin
      if (chk_leader) check_eq("leader_id", 32'(leader_id), 32'(model_leader(cyc - 1)));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         m_wr[i] = -1000; m_wr_prev[i] = -1000; m_score[i] = '0; m_old[i] = '0;
      end

      // Reset state
      repeat (3) tick();
      check_eq("rst_char_vld", 32'(char_vld), 32'd0);
      check_eq("rst_char_code", 32'(char_code), 32'h20);
      check_eq("rst_leader", 32'(leader_id), 32'd0);
      check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      chk_leader = 1'b1;
      tick();

      // Empty table layout
      lookup(0, 5); lookup(0, 0); lookup(1, 10); lookup(1, 6); lookup(4, 3);
      lookup(5, 0); lookup(5, 14); lookup(5, 15); lookup(15, 15);

      // Local write of slot 1
      board_id = 2'd1;
      model_set(1, 24'h000123);
      drive(1'b1, 24'h000123, 1'b0, '0, 1'b0, '0);
      check_eq("leader_latency", 32'(leader_id), 32'd0);
      tick();
      check_eq("leader_first", 32'(leader_id), 32'd1);
      for (int c = 10; c < 16; c++) lookup(1, c);

      // Three frames: local and link 1 collide on slot 2, link 2 hits slot 3
      board_id = 2'd2;
      model_set(2, 24'h000500);
      model_set(3, 24'h000900);
      drive(1'b1, 24'h000500, 1'b1, {2'd2, 24'h000900}, 1'b1, {2'd3, 24'h000900});
      tick();
      check_eq("leader_conflict", 32'(leader_id), 32'd3);
      check_eq("err_conflict", 32'(err_cnt), 32'd0);
      for (int c = 10; c < 16; c++) lookup(2, c);
      lookup(3, 13); lookup(3, 15); lookup(5, 14);

      // Bad ID and bad nibble in one cycle
      drive(1'b0, '0, 1'b1, {2'd0, 24'h000001}, 1'b1, {2'd3, 24'h0000A1});
      check_eq("err_two_drops", 32'(err_cnt), 32'd2);
      lookup(3, 15); lookup(3, 14);
      board_id = 2'd1;
      drive(1'b1, 24'h00000F, 1'b0, '0, 1'b0, '0);
      check_eq("err_local_bad", 32'(err_cnt), 32'd3);
      board_id = 2'd0;
      lookup(5, 14);
      board_id = 2'd3;
      lookup(5, 14);

      // Saturation of the error counter
      for (int k = 0; k < 127; k++) drive(1'b0, '0, 1'b1, {2'd0, 24'h1}, 1'b1, {2'd1, 24'hF00000});
      check_eq("err_saturate", 32'(err_cnt), 32'd255);

      // Timeout: single write, then watch the slot age out
      repeat (12) tick();
      model_set(3, 24'h000042);
      drive(1'b0, '0, 1'b0, '0, 1'b1, {2'd3, 24'h000042});
      for (int k = 0; k < 12; k++) lookup(3, 15);
      check_eq("leader_after_timeout", 32'(leader_id), 32'd0);

      // Refresh landing in the expiry cycle keeps the slot present
      model_set(3, 24'h000055);
      drive(1'b0, '0, 1'b0, '0, 1'b1, {2'd3, 24'h000055});
      for (int k = 0; k < 9; k++) lookup(3, 15);
      model_set(3, 24'h000056);
      drive(1'b0, '0, 1'b0, '0, 1'b1, {2'd3, 24'h000056});
      check_eq("leader_refresh", 32'(leader_id), 32'd3);
      for (int k = 0; k < 10; k++) lookup(3, 10 + (k % 6));

      // Tie between slots 1 and 2 goes to the lower ID
      repeat (12) tick();
      board_id = 2'd1;
      model_set(1, 24'h000777);
      model_set(2, 24'h000777);
      drive(1'b1, 24'h000777, 1'b1, {2'd2, 24'h000777}, 1'b0, '0);
      tick();
      check_eq("leader_tie", 32'(leader_id), 32'd1);
      lookup(1, 9); lookup(2, 9); lookup(3, 9); lookup(1, 15); lookup(2, 12);

      // Reset during a lookup drops the request
      repeat (2) tick();
      chk_leader = 1'b0;
      char_xy  = {4'd0, 4'd5};
      char_req = 1'b1;
      rst      = 1'b1;
      tick();
      char_req = 1'b0;
      check_eq("rst_mid_vld", 32'(char_vld), 32'd0);
      check_eq("rst_mid_code", 32'(char_code), 32'h20);
      check_eq("rst_mid_leader", 32'(leader_id), 32'd0);
      check_eq("rst_mid_err", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      repeat (3) tick();
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
